seq_divider: RTL

Multi-cycle restoring divider for 32-bit operands. It is the inverse companion of the team's sequential Booth multiplier and uses the same operand naming and sign-select convention. It produces quotient and remainder one bit per clock, with a start/done handshake. It sits beside the multiplier in the arithmetic datapath, and multiplier outputs can be checked by dividing back.

---
 rtl/seq_divider.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
//   Multi-cycle restoring divider. Produces one quotient bit per clock and
//   supports unsigned or two's-complement operands. It is the inverse
//   companion of the sequential Booth multiplier and uses the same operand
//   naming and sign-select convention.
//
// Optional feature macro: SEQ_DIVIDER_FAST_ZERO_EN
//   Defined     : a zero dividend or zero divisor skips RUN and goes from IDLE
//                 straight to FIX. The result values are unchanged.
//   Not defined : every operation takes the full WIDTH+1 edge latency.
//
// Handshake (start/done):
//   start is sampled only while busy=0 (IDLE). A high start on an IDLE edge
//   captures in_a, in_b and sign, and busy rises on that same edge. A start
//   seen while busy=1 is dropped and nothing is queued. done pulses high for
//   exactly one cycle, in the same cycle that busy falls. quotient, remainder
//   and div_by_zero are valid from the done cycle and hold until the next
//   result is written.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   start        operation request (sampled only in IDLE)
//   sign         1 = two's-complement operands, 0 = unsigned
//   in_a         dividend
//   in_b         divisor
//   quotient     registered quotient
//   remainder    registered remainder (its sign follows the dividend)
//   div_by_zero  registered; set together with done when the divisor was 0
//   busy         high while the FSM is not in IDLE
//   done         one-cycle completion pulse
//   o_dbg_state  current FSM state (0 = IDLE, 1 = RUN, 2 = FIX)
// ---------------------------------------------------------------------------
module seq_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             busy,
    output logic             done,
    output logic [1:0]       o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_a_orig;
    logic             r_negq;
    logic             r_negr;
    logic             r_dz;

    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_rem_fix;
    logic             w_fast_zero;

    // The magnitude of the most-negative input wraps to the same bit
    // pattern. Read as unsigned, that pattern is 2^(WIDTH-1), which is the
    // correct magnitude.
    assign w_abs_a = (sign && in_a[WIDTH-1]) ? -in_a : in_a;
    assign w_abs_b = (sign && in_b[WIDTH-1]) ? -in_b : in_b;

    // Restoring step. The extra top bit lets the trial subtraction report a
    // borrow without overflowing.
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_trial = w_shift - {1'b0, r_div};

    assign w_quo_fix = r_negq ? -r_quo : r_quo;
    assign w_rem_fix = r_negr ? -r_rem : r_rem;

`ifdef SEQ_DIVIDER_FAST_ZERO_EN
    assign w_fast_zero = (in_a == '0) || (in_b == '0);
`else
    assign w_fast_zero = 1'b0;
`endif

    assign busy        = (r_state != S_IDLE);
    assign o_dbg_state = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_div       <= '0;
            r_a_orig    <= '0;
            r_negq      <= 1'b0;
            r_negr      <= 1'b0;
            r_dz        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_rem    <= '0;
                        r_quo    <= w_abs_a;
                        r_div    <= w_abs_b;
                        r_a_orig <= in_a;
                        r_negq   <= sign & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
                        r_negr   <= sign & in_a[WIDTH-1];
                        r_dz     <= (in_b == '0);
                        r_cnt    <= '0;
                        r_state  <= w_fast_zero ? S_FIX : S_RUN;
                    end
                end
                S_RUN: begin
                    if (!w_trial[WIDTH]) begin
                        r_rem <= w_trial[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], 1'b1};
                    end else begin
                        r_rem <= w_shift[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], 1'b0};
                    end
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_CNT) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    // A zero divisor returns all ones and the raw dividend
                    // bits, so the sign fix-up is skipped in that case.
                    if (r_dz) begin
                        quotient  <= '1;
                        remainder <= r_a_orig;
                    end else begin
                        quotient  <= w_quo_fix;
                        remainder <= w_rem_fix;
                    end
                    div_by_zero <= r_dz;
                    done        <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
